// File: rtl/bnn_frame_loader.sv
// rtl/bnn_frame_loader.sv - streams one pixel frame into BRAM port A and holds frame_ready until acknowledged
module bnn_frame_loader #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 784,
  parameter int BINARIZE     = 1,
  parameter int THRESHOLD    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              bram_cea,
  output logic              bram_wrea,
  output logic [ADDR_W-1:0] bram_ada,
  output logic [DATA_W-1:0] bram_dina,
  output logic              busy,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [DATA_W-1:0] THR      = DATA_W'(THRESHOLD);

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [DATA_W-1:0] pix_xf;
  logic              accept;

  assign s_ready = (state == LOAD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    pix_xf = s_data;
    if (BINARIZE != 0)
      pix_xf = {{(DATA_W-1){1'b0}}, (s_data >= THR)};
  end

  // The write pulse trails the accept by one cycle, so FLUSH covers the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      frame_ready <= 1'b0;
      bram_cea    <= 1'b0;
      bram_wrea   <= 1'b0;
      bram_ada    <= '0;
      bram_dina   <= '0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      bram_cea  <= 1'b0;
      bram_wrea <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            pix_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept) begin
            bram_cea  <= 1'b1;
            bram_wrea <= 1'b1;
            bram_ada  <= pix_cnt;
            bram_dina <= pix_xf;
            pix_cnt   <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_IDX)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          busy <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            state       <= READY;
            frame_ready <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end
        end
        READY: begin
          if (frame_ack) begin
            state       <= IDLE;
            frame_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_frame_loader.sv
// tb/tb_bnn_frame_loader.sv - scoreboard bench: binarized 784-pixel, raw 784-pixel and 1-pixel loaders
module tb_bnn_frame_loader;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       start, abort, s_valid, frame_ack;
  logic [2:0][7:0]  s_data;
  logic [2:0]       s_ready, frame_ready, bram_cea, bram_wrea, busy;
  logic [2:0][9:0]  bram_ada;
  logic [2:0][7:0]  bram_dina;
  logic [2:0][7:0]  frame_count;

  // instance 0: binarized 784, instance 1: raw 784, instance 2: binarized single pixel
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bnn_frame_loader #(
      .ADDR_W(10), .DATA_W(8),
      .FRAME_PIXELS(g == 2 ? 1 : 784),
      .BINARIZE(g == 1 ? 0 : 1),
      .THRESHOLD(128)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .start(start[g]), .abort(abort[g]),
      .s_valid(s_valid[g]), .s_data(s_data[g]), .s_ready(s_ready[g]),
      .frame_ready(frame_ready[g]), .frame_ack(frame_ack[g]),
      .bram_cea(bram_cea[g]), .bram_wrea(bram_wrea[g]),
      .bram_ada(bram_ada[g]), .bram_dina(bram_dina[g]),
      .busy(busy[g]), .frame_count(frame_count[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {int inst; int addr; int data;} wr_t;
  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int xform(input int g, input logic [7:0] d);
    if (g == 1) return int'(d);
    return (d >= 8'd128) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    for (int g = 0; g < 3; g++) begin
      if (bram_cea[g] || bram_wrea[g])
        chk($sformatf("cea_eq_wrea[%0d]", g), bram_cea[g], bram_wrea[g]);
      if (bram_wrea[g]) begin
        chk($sformatf("write_expected[%0d]", g), exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("write_inst[%0d]", g), g, e.inst);
          chk($sformatf("write_addr[%0d]", g), bram_ada[g], e.addr);
          chk($sformatf("write_data[%0d]", g), bram_dina[g], e.data);
        end
      end
    end
  end

  task automatic start_pulse(input int g, input bit with_abort);
    @(negedge clk);
    start[g] = 1'b1;
    abort[g] = with_abort;
    @(negedge clk);
    start[g] = 1'b0;
    abort[g] = 1'b0;
    chk("start_s_ready", s_ready[g], 1);
    chk("start_busy", busy[g], 1);
  endtask

  // returns at the negedge where the final pixel is presented
  task automatic load(input int g, input int n, input int gap_pct, input bit rand_data);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4000) begin
      @(negedge clk);
      chk("s_ready_load", s_ready[g], 1);
      s_valid[g] = ($urandom_range(99) >= gap_pct);
      s_data[g]  = rand_data ? 8'($urandom) : 8'(acc);
      if (s_valid[g]) begin
        exp_q.push_back('{g, acc, xform(g, s_data[g])});
        acc++;
      end
      cyc++;
    end
    chk("load_timeout", acc, n);
  endtask

  task automatic finish_frame(input int g, input int exp_cnt);
    @(negedge clk);
    s_valid[g] = 1'b0;
    chk("flush_frame_ready", frame_ready[g], 0);
    chk("flush_busy", busy[g], 1);
    chk("flush_s_ready", s_ready[g], 0);
    @(negedge clk);
    chk("frame_ready_rise", frame_ready[g], 1);
    chk("frame_count", frame_count[g], exp_cnt);
    chk("ready_busy", busy[g], 0);
    chk("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic ack(input int g);
    @(negedge clk);
    frame_ack[g] = 1'b1;
    @(negedge clk);
    frame_ack[g] = 1'b0;
    chk("ack_frame_ready", frame_ready[g], 0);
  endtask

  task automatic chk_zero(input int g);
    chk($sformatf("outputs_zero[%0d]", g),
        {s_ready[g], frame_ready[g], bram_cea[g], bram_wrea[g], busy[g],
         bram_ada[g], bram_dina[g], frame_count[g]}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0; abort = '0; s_valid = '0; frame_ack = '0; s_data = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_zero(g);
    rst_n = 1'b1;

    s_valid = 3'b111;
    repeat (20) begin
      @(negedge clk);
      s_data = 24'($urandom);
      for (int g = 0; g < 3; g++) begin
        chk("idle_s_ready", s_ready[g], 0);
        chk("idle_wrea", bram_wrea[g], 0);
      end
    end
    s_valid = '0;

    // continuous binarized frame
    start_pulse(0, 1'b0);
    load(0, 784, 0, 1'b0);
    finish_frame(0, 1);

    // hold in READY, ignoring a stray start
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start[0] = (i == 20);
      chk("hold_frame_ready", frame_ready[0], 1);
      chk("hold_s_ready", s_ready[0], 0);
    end
    start[0] = 1'b0;
    ack(0);
    repeat (3) begin
      @(negedge clk);
      chk("post_ack_idle", {busy[0], s_ready[0]}, 0);
    end

    // abort after 300 accepts, with an accept on the abort edge
    start_pulse(0, 1'b0);
    load(0, 300, 0, 1'b1);
    @(negedge clk);
    abort[0]   = 1'b1;
    s_data[0]  = 8'($urandom);
    @(negedge clk);
    abort[0]   = 1'b0;
    s_valid[0] = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_s_ready", s_ready[0], 0);
    chk("abort_frame_ready", frame_ready[0], 0);
    chk("abort_count", frame_count[0], 1);
    repeat (5) @(negedge clk);
    chk("abort_no_extra_write", exp_q.size(), 0);

    start_pulse(0, 1'b0);
    load(0, 784, 0, 1'b1);
    finish_frame(0, 2);
    ack(0);

    // gapped raw frame
    start_pulse(1, 1'b0);
    load(1, 784, 30, 1'b1);
    finish_frame(1, 1);
    ack(1);

    // single-pixel frame; start wins over abort in IDLE, abort ignored in READY
    start_pulse(2, 1'b1);
    load(2, 1, 0, 1'b1);
    finish_frame(2, 1);
    @(negedge clk);
    abort[2] = 1'b1;
    @(negedge clk);
    abort[2] = 1'b0;
    chk("ready_abort_ignored", frame_ready[2], 1);
    ack(2);

    // abort during FLUSH
    start_pulse(2, 1'b0);
    load(2, 1, 0, 1'b1);
    @(negedge clk);
    s_valid[2] = 1'b0;
    abort[2]   = 1'b1;
    @(negedge clk);
    abort[2]   = 1'b0;
    chk("flush_abort_busy", busy[2], 0);
    chk("flush_abort_count", frame_count[2], 1);
    @(negedge clk);
    chk("flush_abort_frame_ready", frame_ready[2], 0);
    chk("flush_abort_writes", exp_q.size(), 0);

    // asynchronous reset in the middle of a load
    start_pulse(0, 1'b0);
    load(0, 10, 0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(0);
    exp_q.delete();
    @(negedge clk);
    s_valid = '0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk_zero(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
